uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmit engine that serialises one parallel word per frame onto a single line. Each frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional even or odd parity bit, and one or two stop bits. Frame format is selected per frame, and every bit lasts a programmable number of clocks. It sits between the register/FIFO side of the design and the TX pad. It replaces the separate TX control FSM, serializer, parity generator and bit counter with one block.

## Interface
Parameters:
- DATA_WIDTH, 8: payload bits per frame; legal range 5–9.
- CLKS_PER_BIT, 1: clock cycles per transmitted bit; must be ≥1. A value of 1 gives one bit per clock.

Ports:
- CLK  in  1  single system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  word to transmit; sampled on the acceptance edge only.
- DATA_VALID  in  1  request to send P_DATA; ignored while Busy=1.
- PAR_EN  in  1  1 = insert a parity bit; sampled at acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at acceptance.
- STOP2  in  1  1 = two stop bits, 0 = one; sampled at acceptance.
- TX_OUT  out  1  registered serial line; idles high.
- Busy  out  1  high for the whole frame.
- Done  out  1  one-cycle pulse on the final cycle of the last stop bit.

## Operation
- Reset (RST=1, asynchronous):
  - TX_OUT=1, Busy=0, Done=0.
  - State = IDLE; all counters and shadow registers cleared.
  - A frame in progress is abandoned with no Done pulse; the line returns high immediately.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - TX_OUT=1, Busy=0.
  - On an edge with DATA_VALID=1, the block latches P_DATA, PAR_EN, PAR_TYP and STOP2 into shadow registers and moves to START.
- START: TX_OUT=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - TX_OUT = shadow[bit_idx], with bit_idx running 0..DATA_WIDTH-1, each index held CLKS_PER_BIT cycles.
  - After bit DATA_WIDTH-1: go to PARITY if PAR_EN_shadow=1, else to STOP1.
- PARITY:
  - TX_OUT = ^shadow_data XOR PAR_TYP_shadow (even → total number of ones, data plus parity, is even).
  - Lasts CLKS_PER_BIT cycles, then STOP1.
- STOP1: TX_OUT=1 for CLKS_PER_BIT cycles, then STOP2 if STOP2_shadow=1, else IDLE.
- STOP2: TX_OUT=1 for CLKS_PER_BIT cycles, then IDLE.
- Done is asserted combinationally from state on the final cycle of the last stop bit: prescale counter = CLKS_PER_BIT-1 in the final stop state.
- Counters:
  - Prescale counter: width $clog2(CLKS_PER_BIT) (minimum 1); wraps to 0 at CLKS_PER_BIT-1.
  - Bit index: width $clog2(DATA_WIDTH); advances only on prescale wrap.
- Changes to P_DATA, PAR_EN, PAR_TYP or STOP2 during a frame have no effect on that frame.
- DATA_VALID while Busy=1 is dropped, not queued; the upstream source holds DATA_VALID until it sees Busy=0.

## Timing
- Acceptance: DATA_VALID=1 and Busy=0 at rising edge k. After edge k, TX_OUT=0 and Busy=1 (zero added latency, no combinational path to TX_OUT).
- Frame length: F = 1 + DATA_WIDTH + PAR_EN + (1+STOP2) bits. Busy stays high for F×CLKS_PER_BIT cycles, edges k..k+F×CLKS_PER_BIT-1.
- Busy falls and TX_OUT stays 1 after edge k+F×CLKS_PER_BIT.
- Done is high in the cycle immediately before Busy falls.
- Back-to-back: with DATA_VALID held high, the next frame is accepted on the first edge where Busy=0. This guarantees exactly one idle-high cycle between frames beyond the stop bits.

## Test plan
- DATA_WIDTH=8, CLKS_PER_BIT=1, P_DATA=0xA5, PAR_EN=0, STOP2=0 → TX_OUT over cycles = 0,1,0,1,0,0,1,0,1,1; Busy high 10 cycles; Done high only in cycle 10.
- Same data, PAR_EN=1: PAR_TYP=0 → parity bit 0; PAR_TYP=1 → parity bit 1; 11-cycle frame with parity in cycle 10.
- P_DATA=0xFF, PAR_EN=1, PAR_TYP=0, STOP2=1 → parity bit 0, two high stop bits, Busy 12 cycles, Done on cycle 12 only.
- CLKS_PER_BIT=4, P_DATA=0x3C, no parity, one stop → each bit held exactly 4 cycles, Busy 40 cycles, TX_OUT sequence 0,0,0,1,1,1,1,0,0,1 per bit.
- Toggle P_DATA, PAR_EN, STOP2 and pulse DATA_VALID mid-frame → frame bits unchanged, no second frame started; DATA_VALID held continuously → frames separated by exactly one idle-high cycle.
- Assert RST during data bit 3 → TX_OUT=1, Busy=0, Done=0 immediately (before the next edge); after release, a new 0x5A frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start bit, LSB-first payload, optional parity, one or two stop bits.
// Frame format is captured per frame; every bit lasts CLKS_PER_BIT clocks.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned PrescW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW   = $clog2(DATA_WIDTH);

  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]   BitLast   = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e                state_q, state_d;
  logic [PrescW-1:0]     presc_q, presc_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  tx_q, tx_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;

  logic                  accept;
  logic                  wrap;

  assign accept = (state_q == StIdle) && DATA_VALID;
  assign wrap   = (presc_q == PrescLast);

  // State, counters and the registered serial line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      presc_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shadow copy of the frame request, frozen for the whole frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
    end
  end

  // Next state: advance one bit each time the prescaler wraps
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bit_d   = bit_q;
    if (state_q == StIdle) begin
      if (DATA_VALID) begin
        state_d = StStart;
        presc_d = '0;
        bit_d   = '0;
      end
    end else if (!wrap) begin
      presc_d = presc_q + PrescW'(1);
    end else begin
      presc_d = '0;
      case (state_q)
        StStart: begin
          state_d = StData;
          bit_d   = '0;
        end
        StData: begin
          if (bit_q == BitLast) begin
            state_d = par_en_q ? StParity : StStop1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
        StParity: state_d = StStop1;
        StStop1:  state_d = stop2_q ? StStop2 : StIdle;
        StStop2:  state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs: line value is computed for the upcoming state so TX_OUT is a plain flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_q[bit_d];
      StParity: tx_d = (^data_q) ^ par_typ_q;
      default:  tx_d = 1'b1;
    endcase
    Busy = (state_q != StIdle);
    Done = wrap && ((state_q == StStop2) || ((state_q == StStop1) && !stop2_q));
  end

  assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: one instance at one clock per bit, one at four clocks per bit.
module tb_uart_tx_frame;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [7:0] p_data;
  logic       dv1;
  logic       dv4;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic       tx1, busy1, done1;
  logic       tx4, busy4, done4;

  int   tests;
  int   fails;
  int   sel;
  exp_t exp_q[$];

  uart_tx_frame #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(1)
  ) dut1 (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (p_data),
    .DATA_VALID(dv1),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .STOP2     (stop2),
    .TX_OUT    (tx1),
    .Busy      (busy1),
    .Done      (done1)
  );

  uart_tx_frame #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(4)
  ) dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (p_data),
    .DATA_VALID(dv4),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .STOP2     (stop2),
    .TX_OUT    (tx4),
    .Busy      (busy4),
    .Done      (done4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected per-cycle line/Busy/Done for one frame, plus the idle cycle after it
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic s2, input int cpb);
    logic b[$];
    exp_t e;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back((^d) ^ pt);
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++) begin
      for (int c = 0; c < cpb; c++) begin
        e.tx   = b[j];
        e.busy = 1'b1;
        e.done = (j == b.size() - 1) && (c == cpb - 1);
        exp_q.push_back(e);
      end
    end
    e.tx   = 1'b1;
    e.busy = 1'b0;
    e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag, input exp_t e);
    exp_t o;
    o = (sel == 0) ? {tx1, busy1, done1} : {tx4, busy4, done4};
    tests++;
    assert (o.tx === e.tx) else begin
      fails++;
      $error("FAIL %s tx: got %b want %b", tag, o.tx, e.tx);
    end
    tests++;
    assert (o.busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy: got %b want %b", tag, o.busy, e.busy);
    end
    tests++;
    assert (o.done === e.done) else begin
      fails++;
      $error("FAIL %s done: got %b want %b", tag, o.done, e.done);
    end
  endtask

  // Pop and compare n cycles, sampling 1 time unit after each rising edge
  task automatic check_cycles(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s scoreboard: got empty queue want entry", tag);
      end else begin
        e = exp_q.pop_front();
        check_now($sformatf("%s[%0d]", tag, i), e);
      end
    end
  endtask

  task automatic check_rest(input string tag);
    check_cycles(exp_q.size(), tag);
  endtask

  task automatic start(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    @(negedge CLK);
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    stop2   = s2;
    if (sel == 0) dv1 = 1'b1;
    else dv4 = 1'b1;
    push_frame(d, pe, pt, s2, (sel == 0) ? 1 : 4);
  endtask

  initial begin
    exp_t idle;
    tests   = 0;
    fails   = 0;
    sel     = 0;
    p_data  = '0;
    dv1     = 1'b0;
    dv4     = 1'b0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    stop2   = 1'b0;
    idle    = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
    RST     = 1'b1;

    #1;
    sel = 0;
    check_now("reset1", idle);
    sel = 1;
    check_now("reset4", idle);
    @(negedge CLK);
    RST = 1'b0;
    sel = 0;
    check_cycles(0, "none");
    @(posedge CLK);
    #1;
    check_now("idle1", idle);

    // 0xA5, no parity, one stop
    start(8'hA5, 1'b0, 1'b0, 1'b0);
    check_cycles(1, "a5");
    dv1 = 1'b0;
    check_rest("a5");

    // 0xA5 even parity, then odd parity
    start(8'hA5, 1'b1, 1'b0, 1'b0);
    check_cycles(1, "a5_even");
    dv1 = 1'b0;
    check_rest("a5_even");
    start(8'hA5, 1'b1, 1'b1, 1'b0);
    check_cycles(1, "a5_odd");
    dv1 = 1'b0;
    check_rest("a5_odd");

    // 0xFF even parity, two stop bits
    start(8'hFF, 1'b1, 1'b0, 1'b1);
    check_cycles(1, "ff_s2");
    dv1 = 1'b0;
    check_rest("ff_s2");

    // Inputs toggled and DATA_VALID pulsed mid-frame must not disturb the frame
    start(8'h33, 1'b1, 1'b1, 1'b0);
    check_cycles(1, "mid");
    dv1 = 1'b0;
    check_cycles(3, "mid");
    p_data  = 8'hCC;
    par_en  = 1'b0;
    par_typ = 1'b0;
    stop2   = 1'b1;
    dv1     = 1'b1;
    check_cycles(1, "mid");
    dv1 = 1'b0;
    check_rest("mid");
    check_cycles(0, "none");
    push_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1);
    exp_q.delete();
    @(posedge CLK);
    #1;
    check_now("mid_noframe", idle);

    // DATA_VALID held: frames separated by exactly one idle-high cycle
    start(8'hC3, 1'b0, 1'b0, 1'b0);
    check_cycles(1, "b2b_1");
    p_data = 8'h81;
    push_frame(8'h81, 1'b0, 1'b0, 1'b0, 1);
    check_cycles(10, "b2b_1");
    check_cycles(1, "b2b_2");
    dv1 = 1'b0;
    check_rest("b2b_2");

    // Four clocks per bit
    sel = 1;
    start(8'h3C, 1'b0, 1'b0, 1'b0);
    check_cycles(1, "cpb4");
    dv4 = 1'b0;
    check_rest("cpb4");

    // Reset during data bit 3 (bit 3 of 0xF0 is 0, so the line visibly returns high)
    sel = 0;
    start(8'hF0, 1'b0, 1'b0, 1'b0);
    check_cycles(1, "rst_pre");
    dv1 = 1'b0;
    check_cycles(4, "rst_pre");
    RST = 1'b1;
    #1;
    check_now("rst_async", idle);
    exp_q.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    start(8'h5A, 1'b0, 1'b0, 1'b0);
    check_cycles(1, "post_rst");
    dv1 = 1'b0;
    check_rest("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
